// File: rtl/alloc_releaser.sv
// Releasing end of the local-buffer allocator: returns space strictly in allocation order and signals block drain.
// Optional: define ALLOC_FALSE_FREE_EN to carry a per-record false-free flag through to o_false_free.
module alloc_releaser #(
    parameter int N_ICFG  = 4,
    parameter int DEPTH   = 8,
    parameter int UBW     = 4,
    parameter int ICFG_BW = $clog2(N_ICFG + 1),
    parameter int PBW     = $clog2(DEPTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               rec_rdy,
    output logic               rec_ack,
    input  logic [ICFG_BW-1:0] i_rec_id,
    input  logic [UBW-1:0]     i_rec_uses,
    input  logic               use_dval,
    input  logic               blkend_rdy,
    output logic               blkend_ack,
    output logic               free_dval,
    output logic [ICFG_BW-1:0] o_free_id,
    output logic               blkdone_dval,
`ifdef ALLOC_FALSE_FREE_EN
    input  logic               i_rec_false,
    output logic               o_false_free,
`endif
    output logic [PBW-1:0]     o_pending
);

    localparam int PTRW = $clog2(DEPTH);
    localparam logic [PBW-1:0] DEPTH_C = PBW'(DEPTH);

    logic [ICFG_BW-1:0] id_mem_q   [DEPTH];
    logic [UBW-1:0]     uses_mem_q [DEPTH];
`ifdef ALLOC_FALSE_FREE_EN
    logic               false_mem_q [DEPTH];
    logic               false_free_q, false_free_d;
`endif

    logic [PTRW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PBW-1:0]     count_q, count_d;
    logic [UBW-1:0]     used_q, used_d;
    logic               free_dval_q, free_dval_d;
    logic [ICFG_BW-1:0] free_id_q, free_id_d;
    logic               blkdone_q, blkdone_d;

    logic               nonempty_s;
    logic [UBW-1:0]     head_uses_s;
    logic               push_s;
    logic               pop_s;

    // Handshake decode; acks depend only on registered state and the current requests.
    always_comb begin
        nonempty_s  = (count_q != '0);
        head_uses_s = uses_mem_q[rd_ptr_q];
        pop_s       = nonempty_s &&
                      ((head_uses_s == '0) || (use_dval && ((used_q + UBW'(1)) == head_uses_s)));
        rec_ack     = !i_rst && rec_rdy && (count_q < DEPTH_C) && !blkend_rdy;
        blkend_ack  = !i_rst && blkend_rdy && !nonempty_s && !pop_s;
        push_s      = rec_ack;
    end

    // Next-state: pointers, occupancy, head use count and the registered release/done pulses.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PTRW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTRW'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + PBW'(1);
            2'b01:   count_d = count_q - PBW'(1);
            default: count_d = count_q;
        endcase
        // A use landing on a zero-use release is intentionally dropped by the clear.
        if (pop_s) begin
            used_d = '0;
        end else if (use_dval && nonempty_s) begin
            used_d = used_q + UBW'(1);
        end else begin
            used_d = used_q;
        end
        free_dval_d = pop_s;
        free_id_d   = pop_s ? id_mem_q[rd_ptr_q] : free_id_q;
        blkdone_d   = blkend_ack;
`ifdef ALLOC_FALSE_FREE_EN
        false_free_d = pop_s ? false_mem_q[rd_ptr_q] : 1'b0;
`endif
    end

    // Control state with synchronous reset; a reset discards all records silently.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            used_q      <= '0;
            free_dval_q <= 1'b0;
            free_id_q   <= '0;
            blkdone_q   <= 1'b0;
`ifdef ALLOC_FALSE_FREE_EN
            false_free_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            used_q      <= used_d;
            free_dval_q <= free_dval_d;
            free_id_q   <= free_id_d;
            blkdone_q   <= blkdone_d;
`ifdef ALLOC_FALSE_FREE_EN
            false_free_q <= false_free_d;
`endif
        end
    end

    // Record storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            id_mem_q[wr_ptr_q]   <= i_rec_id;
            uses_mem_q[wr_ptr_q] <= i_rec_uses;
`ifdef ALLOC_FALSE_FREE_EN
            false_mem_q[wr_ptr_q] <= i_rec_false;
`endif
        end
    end

    assign free_dval    = free_dval_q;
    assign o_free_id    = free_id_q;
    assign blkdone_dval = blkdone_q;
    assign o_pending    = count_q;
`ifdef ALLOC_FALSE_FREE_EN
    assign o_false_free = false_free_q;
`endif

endmodule

// File: tb/tb_alloc_releaser.sv
// Table-driven bench for alloc_releaser with a scoreboard of expected free ids.
module tb_alloc_releaser;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       rec_rdy;
    logic       rec_ack;
    logic [2:0] i_rec_id;
    logic [3:0] i_rec_uses;
    logic       use_dval;
    logic       blkend_rdy;
    logic       blkend_ack;
    logic       free_dval;
    logic [2:0] o_free_id;
    logic       blkdone_dval;
    logic [3:0] o_pending;
`ifdef ALLOC_FALSE_FREE_EN
    logic       i_rec_false;
    logic       o_false_free;
`endif

    alloc_releaser dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .rec_rdy      (rec_rdy),
        .rec_ack      (rec_ack),
        .i_rec_id     (i_rec_id),
        .i_rec_uses   (i_rec_uses),
        .use_dval     (use_dval),
        .blkend_rdy   (blkend_rdy),
        .blkend_ack   (blkend_ack),
        .free_dval    (free_dval),
        .o_free_id    (o_free_id),
        .blkdone_dval (blkdone_dval),
`ifdef ALLOC_FALSE_FREE_EN
        .i_rec_false  (i_rec_false),
        .o_false_free (o_false_free),
`endif
        .o_pending    (o_pending)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic       rr;
        logic [2:0] id;
        logic [3:0] uses;
        logic       ud;
        logic       br;
        logic       e_rack;
        logic       e_back;
        logic       e_free;
        logic [2:0] e_fid;
        logic       e_done;
        logic [3:0] e_pend;
    } vec_t;

    vec_t       tbl [128];
    int         n_rows;
    int         n_checks;
    int         n_err;
    logic [2:0] exp_q [$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int rr, input int id, input int uses, input int ud, input int br,
                       input int e_rack, input int e_back, input int e_free, input int e_fid,
                       input int e_done, input int e_pend);
        tbl[n_rows].rr     = rr[0];
        tbl[n_rows].id     = id[2:0];
        tbl[n_rows].uses   = uses[3:0];
        tbl[n_rows].ud     = ud[0];
        tbl[n_rows].br     = br[0];
        tbl[n_rows].e_rack = e_rack[0];
        tbl[n_rows].e_back = e_back[0];
        tbl[n_rows].e_free = e_free[0];
        tbl[n_rows].e_fid  = e_fid[2:0];
        tbl[n_rows].e_done = e_done[0];
        tbl[n_rows].e_pend = e_pend[3:0];
        n_rows++;
    endtask

    // Drive one row at the falling edge, check acks before the rising edge, outputs 1 time unit after it.
    task automatic run_vec(input vec_t v, input int idx);
        logic [2:0] exp_id;
        rec_rdy    = v.rr;
        i_rec_id   = v.id;
        i_rec_uses = v.uses;
        use_dval   = v.ud;
        blkend_rdy = v.br;
        #1;
        chk($sformatf("rec_ack row %0d", idx), int'(rec_ack), int'(v.e_rack));
        chk($sformatf("blkend_ack row %0d", idx), int'(blkend_ack), int'(v.e_back));
        if (v.e_free) exp_q.push_back(v.e_fid);
        @(posedge i_clk);
        #1;
        chk($sformatf("free_dval row %0d", idx), int'(free_dval), int'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            exp_id = exp_q.pop_front();
            if (free_dval) chk($sformatf("o_free_id row %0d", idx), int'(o_free_id), int'(exp_id));
        end
        chk($sformatf("blkdone_dval row %0d", idx), int'(blkdone_dval), int'(v.e_done));
        chk($sformatf("free_done_overlap row %0d", idx), int'(free_dval & blkdone_dval), 0);
        chk($sformatf("o_pending row %0d", idx), int'(o_pending), int'(v.e_pend));
        @(negedge i_clk);
    endtask

    initial begin
        int start;
        n_checks = 0;
        n_err    = 0;
        n_rows   = 0;
        i_rst      = 1'b1;
        rec_rdy    = 1'b1;
        blkend_rdy = 1'b1;
        i_rec_id   = 3'd0;
        i_rec_uses = 4'd0;
        use_dval   = 1'b0;
`ifdef ALLOC_FALSE_FREE_EN
        i_rec_false = 1'b0;
`endif

        // rr id uses ud br | rack back free fid done pend
        add(1,2,3,0,0, 1,0,0,0,0,1);
        add(0,0,0,1,0, 0,0,0,0,0,1);
        add(0,0,0,0,0, 0,0,0,0,0,1);
        add(0,0,0,1,0, 0,0,0,0,0,1);
        add(0,0,0,1,0, 0,0,1,2,0,0);
        add(1,1,0,0,0, 1,0,0,0,0,1);
        add(1,3,0,0,0, 1,0,1,1,0,1);
        add(1,0,2,0,0, 1,0,1,3,0,1);
        add(0,0,0,0,0, 0,0,0,0,0,1);
        add(0,0,0,1,0, 0,0,0,0,0,1);
        add(0,0,0,1,0, 0,0,1,0,0,0);
        add(0,0,0,1,0, 0,0,0,0,0,0);
        add(1,4,1,1,0, 1,0,0,0,0,1);
        add(0,0,0,0,0, 0,0,0,0,0,1);
        add(0,0,0,1,0, 0,0,1,4,0,0);
        add(1,1,1,0,0, 1,0,0,0,0,1);
        add(1,2,1,0,0, 1,0,0,0,0,2);
        add(1,4,1,0,1, 0,0,0,0,0,2);
        add(1,4,1,1,1, 0,0,1,1,0,1);
        add(1,4,1,1,1, 0,0,1,2,0,0);
        add(1,4,1,0,1, 0,1,0,0,1,0);
        add(1,4,1,0,0, 1,0,0,0,0,1);
        add(0,0,0,1,0, 0,0,1,4,0,0);
        for (int k = 0; k < 8; k++) add(1, k % 5, 1, 0, 0, 1, 0, 0, 0, 0, k + 1);
        add(1,3,0,0,0, 0,0,0,0,0,8);
        add(1,3,0,1,0, 0,0,1,0,0,7);
        add(1,3,0,0,0, 1,0,0,0,0,8);
        for (int k = 1; k < 8; k++) add(0, 0, 0, 1, 0, 0, 0, 1, k % 5, 0, 8 - k);
        add(0,0,0,0,0, 0,0,1,3,0,0);
        add(1,1,2,0,0, 1,0,0,0,0,1);
        add(1,2,2,0,0, 1,0,0,0,0,2);
        add(1,3,2,0,0, 1,0,0,0,0,3);

        @(posedge i_clk);
        #1;
        chk("rec_ack in reset", int'(rec_ack), 0);
        chk("blkend_ack in reset", int'(blkend_ack), 0);
        @(posedge i_clk);
        #1;
        chk("reset free_dval", int'(free_dval), 0);
        chk("reset o_free_id", int'(o_free_id), 0);
        chk("reset blkdone_dval", int'(blkdone_dval), 0);
        chk("reset o_pending", int'(o_pending), 0);
        @(negedge i_clk);
        i_rst      = 1'b0;
        rec_rdy    = 1'b0;
        blkend_rdy = 1'b0;

        for (int i = 0; i < n_rows; i++) run_vec(tbl[i], i);

        // Mid-operation reset with three records held.
        i_rst      = 1'b1;
        rec_rdy    = 1'b1;
        blkend_rdy = 1'b1;
        use_dval   = 1'b1;
        #1;
        chk("rec_ack mid reset", int'(rec_ack), 0);
        chk("blkend_ack mid reset", int'(blkend_ack), 0);
        @(posedge i_clk);
        #1;
        chk("o_pending after reset", int'(o_pending), 0);
        chk("free_dval after reset", int'(free_dval), 0);
        @(negedge i_clk);
        i_rst      = 1'b0;
        rec_rdy    = 1'b0;
        blkend_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge i_clk);
            #1;
            chk($sformatf("no free after reset %0d", i), int'(free_dval), 0);
            chk($sformatf("pending after reset %0d", i), int'(o_pending), 0);
            @(negedge i_clk);
        end
        use_dval = 1'b0;

        start = n_rows;
        add(1,3,1,0,0, 1,0,0,0,0,1);
        add(0,0,0,1,0, 0,0,1,3,0,0);
        for (int i = start; i < n_rows; i++) run_vec(tbl[i], i);

`ifdef ALLOC_FALSE_FREE_EN
        rec_rdy     = 1'b1;
        i_rec_id    = 3'd1;
        i_rec_uses  = 4'd1;
        i_rec_false = 1'b1;
        @(posedge i_clk);
        #1;
        chk("false rec pending", int'(o_pending), 1);
        @(negedge i_clk);
        rec_rdy     = 1'b0;
        i_rec_false = 1'b0;
        use_dval    = 1'b1;
        @(posedge i_clk);
        #1;
        chk("false free_dval", int'(free_dval), 1);
        chk("false o_free_id", int'(o_free_id), 1);
        chk("false o_false_free", int'(o_false_free), 1);
        @(negedge i_clk);
        use_dval    = 1'b0;
        rec_rdy     = 1'b1;
        i_rec_id    = 3'd2;
        i_rec_uses  = 4'd0;
        @(posedge i_clk);
        @(negedge i_clk);
        rec_rdy     = 1'b0;
        @(posedge i_clk);
        #1;
        chk("true free_dval", int'(free_dval), 1);
        chk("true o_false_free", int'(o_false_free), 0);
        @(negedge i_clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
